// File: rtl/dmem_bus_if.sv
// Data-memory bus interface between the CPU mem stage and an external
// valid/ready data bus. It turns a single-cycle load/store into a bus
// transaction and stalls the pipeline until the access completes. It also
// flags misaligned word requests and aborts accesses that time out.
module dmem_bus_if #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              addr_err,
  output logic              bus_err,
  output logic              bus_valid,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic       aligned;
  logic       timed_out;
  logic       accept;
  logic       capture;
  logic       abort;

  assign aligned     = (req_addr[1:0] == 2'b00);
  assign timed_out   = (cnt == TIMEOUT_C);
  assign bus_valid   = (state == REQ);
  assign rdata_valid = (state == DONE) && !bus_write;

  // Next-state decode plus the pipeline stall and the datapath strobes.
  // Completion is tested before the timeout so that an access finishing
  // on the very cycle the counter reaches its limit is not flagged.
  always_comb begin
    state_n = state;
    stall   = 1'b0;
    accept  = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && aligned) begin
          stall   = 1'b1;
          accept  = 1'b1;
          state_n = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus_ready && bus_write) begin
          state_n = DONE;
        end else if (bus_ready && bus_rvalid) begin
          capture = 1'b1;
          state_n = DONE;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_n = DONE;
        end else if (bus_ready) begin
          state_n = WAIT_R;
        end
      end
      WAIT_R: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          capture = 1'b1;
          state_n = DONE;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register and the cycle counter that bounds REQ plus WAIT_R.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= 8'd0;
      end else if (state == REQ || state == WAIT_R) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Latched bus request, load result and the one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_write <= 1'b0;
      rdata     <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      addr_err <= (state == IDLE) && req_valid && !aligned;
      bus_err  <= abort;
      if (accept) begin
        bus_addr  <= req_addr;
        bus_wdata <= req_wdata;
        bus_write <= req_write;
      end
      if (capture) begin
        rdata <= bus_rdata;
      end else if (abort && !bus_write) begin
        rdata <= ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if. Two instances share all inputs: one
// with the default timeout for normal traffic and one with a short timeout
// for abort and boundary cases. The bench plays the bus slave and keeps a
// scoreboard of expected completions.
module tb_dmem_bus_if;

  localparam int T_A = 255;
  localparam int T_B = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        stall_a, rdata_valid_a, addr_err_a, bus_err_a, bus_valid_a, bus_write_a;
  logic [31:0] rdata_a, bus_addr_a, bus_wdata_a;
  logic        stall_t, rdata_valid_t, addr_err_t, bus_err_t, bus_valid_t, bus_write_t;
  logic [31:0] rdata_t, bus_addr_t, bus_wdata_t;

  logic        sel_t = 1'b0;
  logic        s_stall, s_rdata_valid, s_addr_err, s_bus_err, s_bus_valid, s_bus_write;
  logic [31:0] s_rdata, s_bus_addr, s_bus_wdata;

  typedef struct {
    logic        is_load;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_rdata_a = '0;
  logic [31:0] model_rdata_t = '0;

  dmem_bus_if #(.TIMEOUT(T_A)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall_a), .rdata(rdata_a), .rdata_valid(rdata_valid_a),
    .addr_err(addr_err_a), .bus_err(bus_err_a),
    .bus_valid(bus_valid_a), .bus_write(bus_write_a), .bus_addr(bus_addr_a), .bus_wdata(bus_wdata_a),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  dmem_bus_if #(.TIMEOUT(T_B)) dut_t (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall_t), .rdata(rdata_t), .rdata_valid(rdata_valid_t),
    .addr_err(addr_err_t), .bus_err(bus_err_t),
    .bus_valid(bus_valid_t), .bus_write(bus_write_t), .bus_addr(bus_addr_t), .bus_wdata(bus_wdata_t),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // Free-running pipeline clock.
  always #5 clk = ~clk;

  // Route the outputs of the instance under test to one set of names.
  always_comb begin
    s_stall       = sel_t ? stall_t       : stall_a;
    s_rdata_valid = sel_t ? rdata_valid_t : rdata_valid_a;
    s_addr_err    = sel_t ? addr_err_t    : addr_err_a;
    s_bus_err     = sel_t ? bus_err_t     : bus_err_a;
    s_bus_valid   = sel_t ? bus_valid_t   : bus_valid_a;
    s_bus_write   = sel_t ? bus_write_t   : bus_write_a;
    s_rdata       = sel_t ? rdata_t       : rdata_a;
    s_bus_addr    = sel_t ? bus_addr_t    : bus_addr_a;
    s_bus_wdata   = sel_t ? bus_wdata_t   : bus_wdata_a;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=expired expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load or store on the selected instance, with the bench acting as
  // the slave. ready_dly counts REQ cycles before bus_ready; rvalid_dly
  // counts cycles from ready to rvalid (0 = same cycle).
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input int ready_dly, input int rvalid_dly,
                               input logic [31:0] rd, input logic keep_next);
    int   tmo, c, endk, vcnt, scnt, exp_v;
    logic done;
    exp_t e;
    exp_t got;
    tmo = sel_t ? T_B : T_A;
    c   = wr ? ready_dly : ready_dly + rvalid_dly;
    e.is_load = !wr;
    if (c > tmo) begin
      e.err = 1'b1;
      endk  = tmo;
      if (!wr) begin
        if (sel_t) model_rdata_t = 32'hDEADBEEF; else model_rdata_a = 32'hDEADBEEF;
      end
    end else begin
      e.err = 1'b0;
      endk  = c;
      if (!wr) begin
        if (sel_t) model_rdata_t = rd; else model_rdata_a = rd;
      end
    end
    e.rdata = sel_t ? model_rdata_t : model_rdata_a;
    exp_v   = ((ready_dly < tmo) ? ready_dly : tmo) + 1;
    sb.push_back(e);

    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    #1;
    checkOutput("accept_stall", 32'(s_stall), 32'd1);
    scnt = 1;
    vcnt = 0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      #1;
      bus_ready  = (k == ready_dly);
      bus_rvalid = !wr && (k == ready_dly + rvalid_dly);
      bus_rdata  = bus_rvalid ? rd : 32'h0BADF00D;
      #1;
      if (s_stall) begin
        scnt++;
        if (s_bus_valid) begin
          vcnt++;
          checkOutput("bus_addr", s_bus_addr, addr);
          checkOutput("bus_write", 32'(s_bus_write), 32'(wr));
          if (wr) checkOutput("bus_wdata", s_bus_wdata, wdata);
        end
      end else begin
        done = 1'b1;
      end
    end
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    got = sb.pop_front();
    if (!done) begin
      checkOutput("done_reached", 32'd0, 32'd1);
    end else begin
      checkOutput("done_rdata_valid", 32'(s_rdata_valid), 32'(got.is_load));
      checkOutput("done_bus_err", 32'(s_bus_err), 32'(got.err));
      checkOutput("done_rdata", s_rdata, got.rdata);
      checkOutput("done_bus_valid", 32'(s_bus_valid), 32'd0);
      checkOutput("stall_cycles", 32'(scnt), 32'(endk + 2));
      checkOutput("bus_valid_cycles", 32'(vcnt), 32'(exp_v));
      @(posedge clk);
      req_valid = keep_next;
      #1;
      checkOutput("after_rdata_valid", 32'(s_rdata_valid), 32'd0);
      checkOutput("after_bus_err", 32'(s_bus_err), 32'd0);
      checkOutput("after_no_reissue", 32'(s_bus_valid), 32'd0);
    end
  endtask

  // Directed sequence of steps.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_stall", 32'(s_stall), 32'd0);
    checkOutput("rst_bus_valid", 32'(s_bus_valid), 32'd0);
    checkOutput("rst_rdata", s_rdata, 32'd0);
    checkOutput("rst_rdata_valid", 32'(s_rdata_valid), 32'd0);
    checkOutput("rst_addr_err", 32'(s_addr_err), 32'd0);
    checkOutput("rst_bus_err", 32'(s_bus_err), 32'd0);
    checkOutput("rst_bus_addr", s_bus_addr, 32'd0);
    checkOutput("rst_bus_wdata", s_bus_wdata, 32'd0);
    checkOutput("rst_bus_write", 32'(s_bus_write), 32'd0);
    rst = 1'b1;

    // Stray rvalid while idle must not touch rdata.
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h0BADF00D;
    @(posedge clk);
    #1;
    bus_rvalid = 1'b0;
    checkOutput("idle_rvalid_rdata", s_rdata, model_rdata_a);
    checkOutput("idle_rvalid_valid", 32'(s_rdata_valid), 32'd0);

    // Store, slave ready at once.
    applyStimulus(1'b1, 32'h10, 32'h12345678, 0, 0, 32'h0, 1'b0);
    // Load, three wait cycles on ready, rvalid two cycles after ready.
    applyStimulus(1'b0, 32'h1C, 32'h0, 3, 2, 32'hCAFEF00D, 1'b0);

    // Misaligned load is dropped with a single addr_err pulse.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h13;
    #1;
    checkOutput("misalign_stall", 32'(s_stall), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    checkOutput("misalign_addr_err", 32'(s_addr_err), 32'd1);
    checkOutput("misalign_bus_valid", 32'(s_bus_valid), 32'd0);
    checkOutput("misalign_stall2", 32'(s_stall), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("misalign_pulse_end", 32'(s_addr_err), 32'd0);
    checkOutput("misalign_bus_idle", 32'(s_bus_valid), 32'd0);

    // Back-to-back loads with req_valid held through DONE.
    applyStimulus(1'b0, 32'h20, 32'h0, 0, 0, 32'h11111111, 1'b1);
    applyStimulus(1'b0, 32'h24, 32'h0, 1, 1, 32'h22222222, 1'b0);

    // Reset while waiting for read data.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h40;
    @(posedge clk);
    #1;
    bus_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_ready = 1'b0;
    #1;
    checkOutput("waitr_stall", 32'(s_stall), 32'd1);
    checkOutput("waitr_bus_valid", 32'(s_bus_valid), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_bus_valid", 32'(s_bus_valid), 32'd0);
    checkOutput("midrst_stall", 32'(s_stall), 32'd0);
    checkOutput("midrst_rdata_valid", 32'(s_rdata_valid), 32'd0);
    checkOutput("midrst_rdata", s_rdata, 32'd0);
    checkOutput("midrst_bus_err", 32'(s_bus_err), 32'd0);
    rst = 1'b1;
    model_rdata_a = '0;
    model_rdata_t = '0;

    // Short-timeout instance: abort, recovery, and the completion-wins edge.
    sel_t = 1'b1;
    applyStimulus(1'b0, 32'h50, 32'h0, 1000, 0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h54, 32'hA5A5A5A5, 1, 0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h58, 32'h0, 2, 2, 32'h600DD00D, 1'b0);
    applyStimulus(1'b1, 32'h5C, 32'h5A5A5A5A, 4, 0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h60, 32'h77777777, 5, 0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
